// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory behind a valid/ready
// request/response handshake with fixed access latency.
module dmem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int IdxW = $clog2(DEPTH);
   localparam int CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);
   localparam logic [33:0] AddrLimit = 34'(DEPTH) * 34'd4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } stateT;

   stateT           state;
   stateT           stateNext;
   logic [CntW-1:0] cnt;
   logic [CntW-1:0] cntNext;
   logic            enterResp;
   logic            accept;

   logic            capWe;
   logic [31:0]     capAddr;
   logic [31:0]     capWdata;
   logic [2:0]      capFunct3;

   logic            curWe;
   logic [31:0]     curAddr;
   logic [31:0]     curWdata;
   logic [2:0]      curFunct3;

   logic [IdxW-1:0] wordIdx;
   logic [1:0]      lane;
   logic            badSize;
   logic            misaligned;
   logic            outOfRange;
   logic            reqErr;
   logic [3:0]      byteEn;
   logic [31:0]     storeData;
   logic [31:0]     memWord;
   logic [7:0]      byteVal;
   logic [15:0]     halfVal;
   logic [31:0]     loadData;
   logic [31:0]     rdataNext;

   logic [31:0]     mem [DEPTH];

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign accept    = req_valid && req_ready;

   // With LATENCY=1 the access completes on the accept edge, so the
   // live request is used in IDLE and the captured copy afterwards.
   assign curWe     = (state == IDLE) ? req_we     : capWe;
   assign curAddr   = (state == IDLE) ? req_addr   : capAddr;
   assign curWdata  = (state == IDLE) ? req_wdata  : capWdata;
   assign curFunct3 = (state == IDLE) ? req_funct3 : capFunct3;

   assign wordIdx    = curAddr[IdxW+1:2];
   assign lane       = curAddr[1:0];
   assign outOfRange = ({2'b00, curAddr} >= AddrLimit);
   assign reqErr     = badSize || misaligned || outOfRange;
   assign memWord    = mem[wordIdx];
   assign byteVal    = memWord[{lane, 3'b000} +: 8];
   assign halfVal    = memWord[{lane[1], 4'b0000} +: 16];
   assign rdataNext  = (reqErr || curWe) ? 32'd0 : loadData;

   // State register with latency counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   // Next state; RESP is entered on the edge the counter hits zero
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      enterResp = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               cntNext = CntLoad;
               if (LATENCY == 1) begin
                  stateNext = RESP;
                  enterResp = 1'b1;
               end else begin
                  stateNext = WAIT;
               end
            end
         end
         WAIT: begin
            cntNext = cnt - CntW'(1);
            if (cnt == CntW'(1)) begin
               stateNext = RESP;
               enterResp = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Size decode: legality, byte enables and lane-replicated store data
   always_comb begin
      badSize    = 1'b0;
      misaligned = 1'b0;
      byteEn     = 4'b0000;
      storeData  = 32'd0;
      unique case (curFunct3)
         3'b000, 3'b100: begin
            byteEn    = 4'b0001 << lane;
            storeData = {4{curWdata[7:0]}};
         end
         3'b001, 3'b101: begin
            misaligned = lane[0];
            byteEn     = lane[1] ? 4'b1100 : 4'b0011;
            storeData  = {2{curWdata[15:0]}};
         end
         3'b010: begin
            misaligned = (lane != 2'b00);
            byteEn     = 4'b1111;
            storeData  = curWdata;
         end
         default: badSize = 1'b1;
      endcase
      if (curWe && curFunct3[2]) begin
         badSize = 1'b1;
      end
   end

   // Load extraction with sign or zero extension
   always_comb begin
      loadData = 32'd0;
      unique case (curFunct3)
         3'b000:  loadData = {{24{byteVal[7]}}, byteVal};
         3'b100:  loadData = {24'd0, byteVal};
         3'b001:  loadData = {{16{halfVal[15]}}, halfVal};
         3'b101:  loadData = {16'd0, halfVal};
         3'b010:  loadData = memWord;
         default: loadData = 32'd0;
      endcase
   end

   // Request capture and response registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         capWe     <= 1'b0;
         capAddr   <= 32'd0;
         capWdata  <= 32'd0;
         capFunct3 <= 3'd0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            capWe     <= req_we;
            capAddr   <= req_addr;
            capWdata  <= req_wdata;
            capFunct3 <= req_funct3;
         end
         if (enterResp) begin
            rsp_rdata <= rdataNext;
            rsp_err   <= reqErr;
         end
      end
   end

   // Store commit on RESP entry; contents survive reset
   always_ff @(posedge clk) begin
      if (rst_n && enterResp && curWe && !reqErr) begin
         for (int i = 0; i < 4; i++) begin
            if (byteEn[i]) begin
               mem[wordIdx][8*i +: 8] <= storeData[8*i +: 8];
            end
         end
      end
   end

endmodule
